// File: rtl/input_sequencer_if.sv
// Shared command encoding for the Tetris core plus the player-input bundle
// that connects the input sequencer to its sources and to the game FSM.
package input_sequencer_pkg;
  typedef enum logic [3:0] {
    NONE       = 4'd0,
    IDLE       = 4'd1,
    WAIT       = 4'd2,
    LEFT       = 4'd3,
    RIGHT      = 4'd4,
    DOWN       = 4'd5,
    DROP       = 4'd6,
    ROTATE     = 4'd7,
    ROTATE_REV = 4'd8,
    HOLD       = 4'd9,
    BAR        = 4'd10,
    SPAWN      = 4'd11,
    LOCK       = 4'd12,
    CLEAR      = 4'd13,
    GAME_OVER  = 4'd14
  } state_type;
endpackage

interface input_sequencer_if #(
  parameter int unsigned LEVEL_W = 4,
  parameter int unsigned QDEPTH  = 16
);
  import input_sequencer_pkg::*;

  logic                   rx_valid;
  logic [7:0]             rx_byte;
  logic [3:0]             btn;
  logic [3:0]             sw_pulse;
  logic [LEVEL_W-1:0]     level;
  logic                   pause;
  state_type              state;
  state_type              control;
  logic [$clog2(QDEPTH):0] q_count;
  logic                   overflow;

  modport master (
    output rx_valid, rx_byte, btn, sw_pulse, level, pause, state,
    input  control, q_count, overflow
  );

  modport slave (
    input  rx_valid, rx_byte, btn, sw_pulse, level, pause, state,
    output control, q_count, overflow
  );
endinterface

// File: rtl/input_sequencer.sv
// Player-input front end: arbitrates UART, buttons (with DAS), switch pulses
// and level-scaled gravity into a command FIFO drained by the game FSM.
module input_sequencer
  import input_sequencer_pkg::*;
#(
  parameter int unsigned QDEPTH       = 16,
  parameter int unsigned GRAVITY_BASE = 50_000_000,
  parameter int unsigned GRAVITY_STEP = 4_000_000,
  parameter int unsigned GRAVITY_MIN  = 5_000_000,
  parameter int unsigned LEVEL_W      = 4,
  parameter int unsigned DAS_DELAY    = 10_000_000,
  parameter int unsigned DAS_RATE     = 3_000_000
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input_sequencer_if.slave io_bus
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  // FIFO state
  state_type         r_mem [QDEPTH];
  logic [PW-1:0]     r_rd;
  logic [PW-1:0]     r_wr;
  logic [CW-1:0]     r_count;
  state_type         r_control;
  logic              r_overflow;

  // Timers and edge tracking
  logic [31:0]       r_grav_cnt;
  logic              r_grav_pend;
  logic [31:0]       r_das_cnt [3];
  logic [3:0]        r_btn_prev;

  logic [LEVEL_W-1:0] w_level;
  logic [31:0]       w_prod;
  logic [31:0]       w_period;
  logic              w_grav_exp;
  logic [3:0]        w_btn_edge;
  logic [2:0]        w_das_rep;
  logic [3:0]        w_btn_ev;
  state_type         w_uart_cmd;
  state_type         w_cand;
  logic              w_cand_valid;
  logic              w_cand_grav;
  logic              w_pop;
  logic              w_full;
  logic              w_push;
  logic              w_drop;
  logic              w_down_push;
  logic [CW-1:0]     w_count_next;
  logic [PW-1:0]     w_rd_next;
  state_type         w_head_next;

  function automatic state_type f_decode(input logic [7:0] b);
    case (b)
      8'h41, 8'h61: return LEFT;
      8'h44, 8'h64: return RIGHT;
      8'h53, 8'h73: return DOWN;
      8'h57, 8'h77, 8'h20: return DROP;
      8'h43, 8'h63: return HOLD;
      8'h58, 8'h78: return ROTATE;
      8'h5A, 8'h7A: return ROTATE_REV;
      8'h42, 8'h62: return BAR;
      default: return NONE;
    endcase
  endfunction

  // Gravity period, clamped without ever letting the subtraction wrap
  assign w_level = io_bus.level;
  assign w_prod  = 32'(w_level) * GRAVITY_STEP;

  always_comb begin
    w_period = GRAVITY_MIN;
    if ((w_prod < GRAVITY_BASE) && ((GRAVITY_BASE - w_prod) > GRAVITY_MIN))
      w_period = GRAVITY_BASE - w_prod;
  end

  assign w_grav_exp = (r_grav_cnt >= (w_period - 32'd1));

  assign w_btn_edge = io_bus.btn & ~r_btn_prev;

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      w_das_rep[i] = io_bus.btn[i] && !w_btn_edge[i] &&
                     (r_das_cnt[i] == (DAS_DELAY - 32'd1));
    end
  end

  assign w_btn_ev   = {w_btn_edge[3], w_btn_edge[2:0] | w_das_rep};
  assign w_uart_cmd = io_bus.rx_valid ? f_decode(io_bus.rx_byte) : NONE;

  // Single-winner arbitration; losers are simply discarded
  always_comb begin
    w_cand      = NONE;
    w_cand_grav = 1'b0;
    if (!io_bus.pause) begin
      if (w_uart_cmd != NONE) begin
        w_cand = w_uart_cmd;
      end else if (|w_btn_ev) begin
        if (w_btn_ev[0])      w_cand = RIGHT;
        else if (w_btn_ev[1]) w_cand = DOWN;
        else if (w_btn_ev[2]) w_cand = LEFT;
        else                  w_cand = HOLD;
      end else if (|io_bus.sw_pulse) begin
        if (io_bus.sw_pulse[0])      w_cand = DROP;
        else if (io_bus.sw_pulse[1]) w_cand = ROTATE;
        else if (io_bus.sw_pulse[2]) w_cand = ROTATE_REV;
        else                         w_cand = BAR;
      end else if (r_grav_pend) begin
        w_cand      = DOWN;
        w_cand_grav = 1'b1;
      end
    end
  end

  assign w_cand_valid = (w_cand != NONE);
  assign w_pop        = (io_bus.state == WAIT) && (r_count != '0);
  assign w_full       = (r_count == CW'(QDEPTH));
  assign w_push       = w_cand_valid && (!w_full || w_pop);
  assign w_drop       = w_cand_valid && !w_push && !w_cand_grav;
  assign w_down_push  = w_push && ((w_cand == DOWN) || (w_cand == DROP));
  assign w_rd_next    = w_pop ? (r_rd + PW'(1)) : r_rd;

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Head is registered, so look ahead to what the next head slot will hold
  always_comb begin
    w_head_next = NONE;
    if (w_count_next != '0) begin
      if (w_push && (r_wr == w_rd_next)) w_head_next = w_cand;
      else                               w_head_next = r_mem[w_rd_next];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= w_cand;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_control  <= NONE;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      r_rd      <= w_rd_next;
      r_count   <= w_count_next;
      r_control <= w_head_next;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_grav_cnt  <= '0;
      r_grav_pend <= 1'b0;
    end else if (!io_bus.pause) begin
      if (w_down_push) begin
        r_grav_cnt <= '0;
      end else if (w_grav_exp) begin
        r_grav_cnt  <= '0;
        r_grav_pend <= 1'b1;
      end else begin
        r_grav_cnt <= r_grav_cnt + 32'd1;
      end
      if (w_push && (w_cand == DOWN)) r_grav_pend <= 1'b0;
    end
  end

  // Edge cycle counts as tick 0, so the first repeat lands DAS_DELAY-1 later
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_btn_prev <= '0;
      for (int unsigned i = 0; i < 3; i++) r_das_cnt[i] <= '0;
    end else begin
      r_btn_prev <= io_bus.btn;
      if (!io_bus.pause) begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (!io_bus.btn[i])     r_das_cnt[i] <= '0;
          else if (w_btn_edge[i]) r_das_cnt[i] <= 32'd1;
          else if (w_das_rep[i])  r_das_cnt[i] <= DAS_DELAY - DAS_RATE;
          else                    r_das_cnt[i] <= r_das_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign io_bus.control  = r_control;
  assign io_bus.q_count  = r_count;
  assign io_bus.overflow = r_overflow;

endmodule
